mult_div_unit: RTL

Execute-stage multiply/divide unit: it owns the HI/LO register pair and performs mult/multu/div/divu with fixed multi-cycle latency. It executes mthi/mtlo and supplies the mfhi/mflo value, which travels down the pipeline as the HL data field toward writeback. It exports a busy flag that the hazard unit combines with a decoded md-instruction in E to stall D/E.

---
 rtl/mult_div_unit.sv | 84 ++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed
// busy window, and executes mthi/mtlo plus the mfhi/mflo read path.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        E_HL_sel,
  output logic        E_busy,
  output logic [31:0] E_HL_data,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  logic [31:0] r_hi, r_lo;
  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [63:0] r_pend;
  logic        r_wen;

  logic [63:0]        w_smul, w_umul;
  logic               w_bzero, w_ovf;
  logic signed [31:0] w_sdvs, w_sq, w_sr;
  logic [31:0]        w_udvs, w_uq, w_ur;

  assign w_smul = 64'($signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B}));
  assign w_umul = {32'b0, E_A} * {32'b0, E_B};

  // Dividing the overflow case by 1 instead of -1 yields exactly the required
  // LO=0x80000000, HI=0; a zero divisor is also steered to 1 (result discarded).
  assign w_bzero = (E_B == 32'd0);
  assign w_ovf   = (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF);
  assign w_sdvs  = (w_bzero || w_ovf) ? 32'sd1 : $signed(E_B);
  assign w_sq    = $signed(E_A) / w_sdvs;
  assign w_sr    = $signed(E_A) % w_sdvs;
  assign w_udvs  = w_bzero ? 32'd1 : E_B;
  assign w_uq    = E_A / w_udvs;
  assign w_ur    = E_A % w_udvs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_pend <= '0;
      r_wen  <= 1'b0;
    end else if (r_busy) begin
      // Ops arriving while busy are dropped; the hazard unit prevents them.
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_busy <= 1'b0;
        if (r_wen) {r_hi, r_lo} <= r_pend;
      end
    end else begin
      case (E_md_op)
        4'd1: begin r_pend <= w_smul; r_cnt <= MC; r_busy <= 1'b1; r_wen <= 1'b1; end
        4'd2: begin r_pend <= w_umul; r_cnt <= MC; r_busy <= 1'b1; r_wen <= 1'b1; end
        4'd3: begin
          r_pend <= {w_sr, w_sq}; r_cnt <= DC; r_busy <= 1'b1; r_wen <= !w_bzero;
        end
        4'd4: begin
          r_pend <= {w_ur, w_uq}; r_cnt <= DC; r_busy <= 1'b1; r_wen <= !w_bzero;
        end
        4'd5:    r_hi <= E_A;
        4'd6:    r_lo <= E_A;
        default: ;
      endcase
    end
  end

  assign E_busy    = r_busy;
  assign HI        = r_hi;
  assign LO        = r_lo;
  assign E_HL_data = E_HL_sel ? r_lo : r_hi;

endmodule
